// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the binary-to-BCD converter.
//   state_e   : controller states (IDLE / SHIFT / DONE)
//   pow10     : constant 10^n, used to build the per-lane overflow threshold
//   cnt_width : width of the shared shift counter, clog2(bin_w + 1)
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Valid up to n = 19; beyond that the 64-bit result wraps.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_dd_lane.sv
// One double-dabble channel: binary shift register, DIGITS add-3 correctors,
// BCD accumulator, overflow flag and the registered result for this channel.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture bin_in, clear accumulator, latch overflow
//   shift    : perform one add-3 + shift-left step
//   finish   : qualifies the final shift; result registers load on it
//   bin_in   : binary value for this channel
//   bcd_out  : registered BCD result, LS digit in low nibble
//   ovf_out  : registered overflow flag (bin_in > 10^DIGITS - 1)
module bcd_dd_lane
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  finish,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  ovf_out
);

    localparam int DW    = DIGITS * 4;
    localparam int CMP_W = (BIN_W > 64) ? BIN_W : 64;
    // With 20+ digits no value of up to 64 bits can overflow.
    localparam bit                OVF_POSSIBLE = (DIGITS <= 19);
    localparam logic [CMP_W-1:0]  MAX_VAL      = CMP_W'(pow10(DIGITS) - 64'd1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    adj;
    logic [DW-1:0]    acc_shift;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic             out_ovf_q, out_ovf_d;

    always_comb begin
        adj = acc_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc_q[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = acc_q[d*4 +: 4] + 4'd3;
            end
        end
        // Top accumulator bit falls off: SATURATE=0 gives value mod 10^DIGITS.
        acc_shift = DW'({adj, bin_q[BIN_W-1]});

        bin_d     = bin_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        out_ovf_d = out_ovf_q;

        if (load) begin
            bin_d = bin_in;
            acc_d = '0;
            ovf_d = OVF_POSSIBLE && (CMP_W'(bin_in) > MAX_VAL);
        end else if (shift) begin
            bin_d = bin_q << 1;
            acc_d = acc_shift;
            // Result registers take the post-shift value on the same edge
            // the controller enters DONE.
            if (finish) begin
                bcd_d     = (SATURATE && ovf_q) ? {DIGITS{4'h9}} : acc_shift;
                out_ovf_d = ovf_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bcd_out = bcd_q;
    assign ovf_out = out_ovf_q;

endmodule

// File: rtl/bcd_dd_converter.sv
// Multi-channel sequential binary-to-BCD converter (double dabble).
// NCH lanes share one controller and bit counter and finish together.
//   clk, rst  : clock, asynchronous active-high reset
//   in_bin    : NCH packed binary inputs, channel i at [i*BIN_W +: BIN_W]
//   in_valid  : input word valid
//   in_ready  : converter accepts a word this cycle
//   out_bcd   : NCH packed BCD results, channel i at [i*DIGITS*4 +: DIGITS*4]
//   out_ovf   : per-channel overflow flags
//   out_valid : out_bcd / out_ovf valid
//   out_ready : consumer accepts the result
module bcd_dd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int NCH      = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*BIN_W-1:0]      in_bin,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NCH*DIGITS*4-1:0]   out_bcd,
    output logic [NCH-1:0]            out_ovf,
    output logic                      out_valid,
    input  logic                      out_ready
);

    if (BIN_W < 1 || DIGITS < 1 || NCH < 1) begin : g_bad_param
        $error("bcd_dd_converter: BIN_W, DIGITS and NCH must all be >= 1");
    end

    localparam int             CW       = cnt_width(BIN_W);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(BIN_W);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           ready_c;
    logic           accept;
    logic           shift_en;
    logic           finish;

    always_comb begin
        ready_c  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && ready_c;
        shift_en = (state_q == SHIFT);
        finish   = shift_en && (cnt_q == CW'(1));

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_LOAD;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = SHIFT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = ready_c;
    assign out_valid = out_valid_q;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        bcd_dd_lane #(
            .BIN_W    (BIN_W),
            .DIGITS   (DIGITS),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (accept),
            .shift   (shift_en),
            .finish  (finish),
            .bin_in  (in_bin[i*BIN_W +: BIN_W]),
            .bcd_out (out_bcd[i*DIGITS*4 +: DIGITS*4]),
            .ovf_out (out_ovf[i])
        );
    end

endmodule

// File: tb/tb_bcd_dd_converter.sv
// Self-checking bench for bcd_dd_converter: table vectors, random words and
// an exhaustive 8-bit sweep compared against an arithmetic reference model,
// plus hand sequences for backpressure and mid-conversion reset.
module tb_bcd_dd_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Group A: BIN_W=6, NCH=3 with DIGITS=2 (sat) and DIGITS=1 (sat / wrap)
    logic [17:0] in_bin_a    = '0;
    logic        in_valid_a  = 1'b0;
    logic        out_ready_a = 1'b0;
    logic [23:0] bcd_a;
    logic [2:0]  ovf_a;
    logic        ir_a, ov_a;
    logic [11:0] bcd_s1, bcd_s0;
    logic [2:0]  ovf_s1, ovf_s0;
    logic        ir_s1, ov_s1, ir_s0, ov_s0;

    // Group C: BIN_W=8, NCH=1 with DIGITS=3 (sat) and DIGITS=2 (wrap)
    logic [7:0]  in_bin_c    = '0;
    logic        in_valid_c  = 1'b0;
    logic        out_ready_c = 1'b0;
    logic [11:0] bcd_c;
    logic [0:0]  ovf_c;
    logic        ir_c, ov_c;
    logic [7:0]  bcd_d;
    logic [0:0]  ovf_d;
    logic        ir_d, ov_d;

    bcd_dd_converter u_a (
        .clk(clk), .rst(rst), .in_bin(in_bin_a), .in_valid(in_valid_a),
        .in_ready(ir_a), .out_bcd(bcd_a), .out_ovf(ovf_a),
        .out_valid(ov_a), .out_ready(out_ready_a)
    );

    bcd_dd_converter #(.BIN_W(6), .DIGITS(1), .NCH(3), .SATURATE(1'b1)) u_s1 (
        .clk(clk), .rst(rst), .in_bin(in_bin_a), .in_valid(in_valid_a),
        .in_ready(ir_s1), .out_bcd(bcd_s1), .out_ovf(ovf_s1),
        .out_valid(ov_s1), .out_ready(out_ready_a)
    );

    bcd_dd_converter #(.BIN_W(6), .DIGITS(1), .NCH(3), .SATURATE(1'b0)) u_s0 (
        .clk(clk), .rst(rst), .in_bin(in_bin_a), .in_valid(in_valid_a),
        .in_ready(ir_s0), .out_bcd(bcd_s0), .out_ovf(ovf_s0),
        .out_valid(ov_s0), .out_ready(out_ready_a)
    );

    bcd_dd_converter #(.BIN_W(8), .DIGITS(3), .NCH(1), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_bin(in_bin_c), .in_valid(in_valid_c),
        .in_ready(ir_c), .out_bcd(bcd_c), .out_ovf(ovf_c),
        .out_valid(ov_c), .out_ready(out_ready_c)
    );

    bcd_dd_converter #(.BIN_W(8), .DIGITS(2), .NCH(1), .SATURATE(1'b0)) u_d (
        .clk(clk), .rst(rst), .in_bin(in_bin_c), .in_valid(in_valid_c),
        .in_ready(ir_d), .out_bcd(bcd_d), .out_ovf(ovf_d),
        .out_valid(ov_d), .out_ready(out_ready_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by division, overflow against 10^digits.
    task automatic model(input logic [63:0] packed_in, input int bw, input int nch,
                         input int digits, input bit sat,
                         output logic [63:0] bcd, output logic [7:0] ovf);
        longint unsigned lim, v, m, dig, mask;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        mask = (64'd1 << bw) - 64'd1;
        bcd = '0;
        ovf = '0;
        for (int ch = 0; ch < nch; ch++) begin
            v = (packed_in >> (ch * bw)) & mask;
            ovf[ch] = (v >= lim);
            m = v % lim;
            for (int k = 0; k < digits; k++) begin
                dig = (ovf[ch] && sat) ? 64'd9 : m % 10;
                m = m / 10;
                bcd = bcd | (dig << (4 * (ch * digits + k)));
            end
        end
    endtask

    // Present a word to group A, take the accept edge, return edges-to-valid.
    task automatic start_a(input logic [17:0] v, output int lat);
        in_bin_a   = v;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        lat = 0;
        while (ov_a !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_a();
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        chk("a_valid_drop", {ov_a, ov_s1, ov_s0}, 3'b000);
    endtask

    task automatic check_a_model(input string tag, input logic [17:0] v);
        logic [63:0] eb;
        logic [7:0]  eo;
        model(64'(v), 6, 3, 2, 1'b1, eb, eo);
        chk({tag, "_a_bcd"}, 64'(bcd_a), eb);
        chk({tag, "_a_ovf"}, 64'(ovf_a), 64'(eo));
        model(64'(v), 6, 3, 1, 1'b1, eb, eo);
        chk({tag, "_s1"}, {ov_s1, ovf_s1, bcd_s1}, {1'b1, eo[2:0], eb[11:0]});
        model(64'(v), 6, 3, 1, 1'b0, eb, eo);
        chk({tag, "_s0"}, {ov_s0, ovf_s0, bcd_s0}, {1'b1, eo[2:0], eb[11:0]});
    endtask

    task automatic run_c(input logic [7:0] v);
        int lat;
        logic [63:0] eb;
        logic [7:0]  eo;
        in_bin_c   = v;
        in_valid_c = 1'b1;
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        lat = 0;
        while (ov_c !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("c_latency", 64'(lat), 64'd8);
        model(64'(v), 8, 1, 3, 1'b1, eb, eo);
        chk("c_result", {ovf_c, bcd_c}, {eo[0], eb[11:0]});
        model(64'(v), 8, 1, 2, 1'b0, eb, eo);
        chk("d_result", {ov_d, ovf_d, bcd_d}, {1'b1, eo[0], eb[7:0]});
        out_ready_c = 1'b1;
        @(posedge clk); #1;
        out_ready_c = 1'b0;
    endtask

    typedef struct {
        logic [17:0] bin;
        logic [23:0] bcd;
        logic [2:0]  ovf;
        logic [11:0] bcd_s1;
        logic [11:0] bcd_s0;
        logic [2:0]  ovf_s;
    } vec_t;

    vec_t vt[6];

    initial begin
        int lat;
        logic [17:0] w;

        vt[0] = '{{6'd59, 6'd59, 6'd23}, 24'h595923, 3'b000, 12'h999, 12'h993, 3'b111};
        vt[1] = '{{6'd0,  6'd9,  6'd10}, 24'h000910, 3'b000, 12'h099, 12'h090, 3'b001};
        vt[2] = '{{6'd0,  6'd0,  6'd63}, 24'h000063, 3'b000, 12'h009, 12'h003, 3'b001};
        vt[3] = '{{6'd63, 6'd42, 6'd1},  24'h634201, 3'b000, 12'h991, 12'h321, 3'b110};
        vt[4] = '{{6'd0,  6'd0,  6'd0},  24'h000000, 3'b000, 12'h000, 12'h000, 3'b000};
        vt[5] = '{{6'd19, 6'd50, 6'd5},  24'h195005, 3'b000, 12'h995, 12'h905, 3'b110};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        chk("reset_a", {ir_a, ov_a, ovf_a, bcd_a}, {1'b1, 1'b0, 3'b000, 24'h0});
        chk("reset_s", {ir_s1, ir_s0, ov_s1, ov_s0, bcd_s1, bcd_s0}, {4'b1100, 24'h0});
        chk("reset_c", {ir_c, ir_d, ov_c, ov_d, bcd_c, bcd_d}, {4'b1100, 20'h0});

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            start_a(vt[i].bin, lat);
            chk("tbl_latency", 64'(lat), 64'd6);
            chk("tbl_a", {ovf_a, bcd_a}, {vt[i].ovf, vt[i].bcd});
            chk("tbl_s1", {ov_s1, ovf_s1, bcd_s1}, {1'b1, vt[i].ovf_s, vt[i].bcd_s1});
            chk("tbl_s0", {ov_s0, ovf_s0, bcd_s0}, {1'b1, vt[i].ovf_s, vt[i].bcd_s0});
            release_a();
            chk("tbl_hold", {ovf_a, bcd_a}, {vt[i].ovf, vt[i].bcd});
        end

        // Random words
        for (int i = 0; i < 40; i++) begin
            w = 18'($urandom);
            start_a(w, lat);
            chk("rnd_latency", 64'(lat), 64'd6);
            check_a_model("rnd", w);
            release_a();
        end

        // Backpressure: result held 20 cycles, then back-to-back accept
        start_a({6'd12, 6'd34, 6'd56}, lat);
        chk("bp_latency", 64'(lat), 64'd6);
        in_bin_a   = {6'd7, 6'd48, 6'd61};
        in_valid_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_stall", {ov_a, ir_a, ovf_a, bcd_a}, {2'b10, 3'b000, 24'h123456});
            @(posedge clk); #1;
        end
        out_ready_a = 1'b1;
        #1;
        chk("bp_ready_bypass", 64'(ir_a), 64'd1);
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        in_valid_a  = 1'b0;
        chk("bp_shift_state", {ov_a, ir_a, bcd_a}, {2'b00, 24'h123456});
        lat = 0;
        while (ov_a !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_next_latency", 64'(lat), 64'd6);
        chk("bp_next_result", 64'(bcd_a), 64'h074861);
        release_a();

        // Reset in the middle of a conversion
        in_bin_a   = {6'd33, 6'd22, 6'd11};
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_shift", {ir_a, ov_a, ovf_a, bcd_a}, {1'b1, 1'b0, 3'b000, 24'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_no_partial", {ov_a, bcd_a}, {1'b0, 24'h0});
        end
        w = {6'd45, 6'd30, 6'd63};
        start_a(w, lat);
        chk("rst_fresh_latency", 64'(lat), 64'd6);
        chk("rst_fresh_a", 64'(bcd_a), 64'h453063);
        check_a_model("rst_fresh", w);
        release_a();

        // Exhaustive 8-bit sweep on group C, then explicit top value
        for (int v = 0; v < 256; v++) begin
            run_c(8'(v));
        end
        in_bin_c   = 8'd255;
        in_valid_c = 1'b1;
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("c_255", {ov_c, ovf_c, bcd_c}, {2'b10, 12'h255});
        chk("d_255_wrap", {ov_d, ovf_d, bcd_d}, {2'b11, 8'h55});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
